dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single data memory port between two requesters: core load/store (C) and DMA/debug (D).
//  Uses round-robin arbitration with a req/ready request handshake and a one-cycle response pulse.
//  Drives the memory's mem_write/mem_read/maskmode/sext/address/write_data pins and captures read_data.
//  Memory writes land on the negedge inside the ACCESS cycle; reads are combinational.
// PARAMETERS
//  DATA_WIDTH  32  data width of the memory and of both requester ports
//  ADDR_WIDTH  32  byte-address width
//  CORE_FIRST  1   1: C wins the first tie after reset; 0: D wins it
// PORTS
//  clk          in   1           single clock, rising edge
//  rstn         in   1           asynchronous, active-low reset
//  c_req/d_req  in   1           request valid; fields held stable until ready seen
//  c_we/d_we    in   1           1=store, 0=load
//  c_mask/d_mask  in  2          00 byte, 01 half, 10 word, 11 illegal
//  c_sext/d_sext  in  1          memory convention: 0=sign-extend, 1=zero-extend (loads only)
//  c_addr/d_addr  in  ADDR_WIDTH  byte address
//  c_wdata/d_wdata in DATA_WIDTH  store data
//  c_ready/d_ready out 1         request accepted this cycle (transfer = req&ready at posedge)
//  c_rvalid/d_rvalid out 1       one-cycle response pulse (loads and stores)
//  c_err/d_err  out  1           qualified by rvalid: misaligned or illegal mask
//  c_rdata/d_rdata out DATA_WIDTH load data, qualified by rvalid; 0 for stores/errors
//  mem_write, mem_read  out 1    to data memory
//  maskmode     out  2           to data memory
//  sext         out  1           to data memory
//  address      out  ADDR_WIDTH  to data memory
//  write_data   out  DATA_WIDTH  to data memory
//  read_data    in   DATA_WIDTH  from data memory (combinational)
// BEHAVIOUR
//  Reset (async, rstn=0): state=IDLE; every output, including the mem_* pins and pointer-derived ready, is 0.
//   prio <= CORE_FIRST ? C : D; any in-flight transaction is dropped with no rvalid.
//   mem_write clears immediately, so a store is suppressed unless its negedge already passed.
//  FSM IDLE -> ACCESS -> RESP -> IDLE. Throughput is 1 access / 3 cycles.
//  IDLE: ready is combinational and high only in IDLE, for exactly one requester:
//   - the only one requesting, or
//   - prio owner on a tie.
//   At posedge with req&ready: latch owner, we, mask, sext, addr, wdata; flip prio to the other
//   requester; go ACCESS. A req dropped before ready has no effect.
//  ACCESS (1 cycle): address/maskmode/write_data come from latched regs.
//   - mem_write = we & ~bad; mem_read = ~we & ~bad.
//   - sext forced 0 when mask=10 (word reads are defined only for sext=0).
//   - bad = (mask==11) | (mask==01 & addr[0]) | (mask==10 & addr[1:0]!=0).
//   - At posedge: rdata_q <= (~we & ~bad) ? read_data : 0; err_q <= bad; go RESP.
//  RESP (1 cycle): owner's rvalid=1, err=err_q, rdata=rdata_q. Other requester's outputs stay 0.
//   mem_* pins are 0 in IDLE and RESP. Go IDLE; a new grant is possible in the following IDLE cycle.
//  A bad access never pulses mem_read/mem_write.
//  Latency: accept at posedge N -> ACCESS in cycle N+1 -> rvalid high in cycle N+2.
//  rdata/err/rvalid are registered; ready is the only combinational output.
//  Requester fields may change freely while its ready is low; after transfer they are don't-care.
// TESTING
//  1 Reset, C only: C sw addr=0x10 wdata=0xDEADBEEF.
//    -> c_ready@N, mem_write=1 for one cycle, c_rvalid@N+2, err=0; mem word 4 = 0xDEADBEEF.
//  2 C lb addr=0x10 sext=0 over mem 0x000000F0 -> c_rdata=0xFFFFFFF0; sext=1 -> 0x000000F0.
//  3 Tie C and D held from reset (CORE_FIRST=1) -> grants C,D,C,D alternating.
//    Grant edges 3 cycles apart; each rvalid reaches only its owner.
//  4 D sh addr=0x13 -> d_rvalid with d_err=1, d_rdata=0, mem_write never 1; mask=11 -> same.
//  5 rstn low mid-ACCESS of a store (before negedge).
//    -> outputs 0 immediately, no rvalid, memory unchanged; after release C wins the first tie.
//  6 C lw while D requests continuously -> D granted only in the IDLE after C's RESP; no overlap of mem_* owners.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter sharing one data memory port between core (C) and DMA/debug (D)
module dmem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter bit CORE_FIRST = 1'b1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  c_req,
    input  logic                  c_we,
    input  logic [1:0]            c_mask,
    input  logic                  c_sext,
    input  logic [ADDR_WIDTH-1:0] c_addr,
    input  logic [DATA_WIDTH-1:0] c_wdata,
    output logic                  c_ready,
    output logic                  c_rvalid,
    output logic                  c_err,
    output logic [DATA_WIDTH-1:0] c_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [1:0]            d_mask,
    input  logic                  d_sext,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_ready,
    output logic                  d_rvalid,
    output logic                  d_err,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_write,
    output logic                  mem_read,
    output logic [1:0]            maskmode,
    output logic                  sext,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] write_data,
    input  logic [DATA_WIDTH-1:0] read_data
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

    state_t                  state;
    logic                    prio_d;
    logic                    owner_d;
    logic                    bad_q;
    logic                    in_idle;
    logic                    grant_c;
    logic                    grant_d;
    logic                    g_we;
    logic                    g_sext;
    logic                    g_bad;
    logic [1:0]              g_mask;
    logic [ADDR_WIDTH-1:0]   g_addr;
    logic [DATA_WIDTH-1:0]   g_wdata;
    logic [DATA_WIDTH-1:0]   load_val;

    // prio_d=1 means D wins the next tie; ready is forced low while in reset
    assign in_idle = rstn & (state == IDLE);
    assign grant_c = in_idle & c_req & (~d_req | ~prio_d);
    assign grant_d = in_idle & d_req & (~c_req | prio_d);
    assign c_ready = grant_c;
    assign d_ready = grant_d;

    assign g_we    = grant_d ? d_we    : c_we;
    assign g_mask  = grant_d ? d_mask  : c_mask;
    assign g_sext  = grant_d ? d_sext  : c_sext;
    assign g_addr  = grant_d ? d_addr  : c_addr;
    assign g_wdata = grant_d ? d_wdata : c_wdata;
    assign g_bad   = (g_mask == 2'b11)
                   | ((g_mask == 2'b01) & g_addr[0])
                   | ((g_mask == 2'b10) & (g_addr[1:0] != 2'b00));

    assign load_val = mem_read ? read_data : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            prio_d     <= ~CORE_FIRST;
            owner_d    <= 1'b0;
            bad_q      <= 1'b0;
            mem_write  <= 1'b0;
            mem_read   <= 1'b0;
            maskmode   <= 2'b00;
            sext       <= 1'b0;
            address    <= '0;
            write_data <= '0;
            c_rvalid   <= 1'b0;
            d_rvalid   <= 1'b0;
            c_err      <= 1'b0;
            d_err      <= 1'b0;
            c_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_c | grant_d) begin
                        owner_d    <= grant_d;
                        prio_d     <= grant_c;
                        bad_q      <= g_bad;
                        mem_write  <= g_we & ~g_bad;
                        mem_read   <= ~g_we & ~g_bad;
                        maskmode   <= g_mask;
                        sext       <= (g_mask == 2'b10) ? 1'b0 : g_sext;
                        address    <= g_addr;
                        write_data <= g_wdata;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_write  <= 1'b0;
                    mem_read   <= 1'b0;
                    maskmode   <= 2'b00;
                    sext       <= 1'b0;
                    address    <= '0;
                    write_data <= '0;
                    c_rvalid   <= ~owner_d;
                    d_rvalid   <= owner_d;
                    c_err      <= ~owner_d & bad_q;
                    d_err      <= owner_d & bad_q;
                    c_rdata    <= owner_d ? '0 : load_val;
                    d_rdata    <= owner_d ? load_val : '0;
                    state      <= RESP;
                end
                RESP: begin
                    c_rvalid <= 1'b0;
                    d_rvalid <= 1'b0;
                    c_err    <= 1'b0;
                    d_err    <= 1'b0;
                    c_rdata  <= '0;
                    d_rdata  <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized and directed bench for dmem_arbiter against a transaction-level model
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        c_req, c_we, c_sext, c_ready, c_rvalid, c_err;
    logic [1:0]  c_mask;
    logic [31:0] c_addr, c_wdata, c_rdata;
    logic        d_req, d_we, d_sext, d_ready, d_rvalid, d_err;
    logic [1:0]  d_mask;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_write, mem_read, sext;
    logic [1:0]  maskmode;
    logic [31:0] address, write_data, read_data;

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .CORE_FIRST(1'b1)) dut (
        .clk(clk), .rstn(rstn),
        .c_req(c_req), .c_we(c_we), .c_mask(c_mask), .c_sext(c_sext), .c_addr(c_addr),
        .c_wdata(c_wdata), .c_ready(c_ready), .c_rvalid(c_rvalid), .c_err(c_err), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_mask(d_mask), .d_sext(d_sext), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ready(d_ready), .d_rvalid(d_rvalid), .d_err(d_err), .d_rdata(d_rdata),
        .mem_write(mem_write), .mem_read(mem_read), .maskmode(maskmode), .sext(sext),
        .address(address), .write_data(write_data), .read_data(read_data)
    );

    typedef struct packed {
        logic        we;
        logic [1:0]  mask;
        logic        sext;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    function automatic logic [31:0] init_word(int i);
        return 32'h9E3779B9 * (i + 1);
    endfunction

    // Data memory: writes on the negedge, reads combinational, sext=0 sign-extends
    logic [31:0] mem [0:63];
    logic [31:0] rd_w;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = init_word(i);
        forever begin
            @(negedge clk);
            if (mem_write) begin
                case (maskmode)
                    2'b00:   mem[address[7:2]][{address[1:0], 3'b000} +: 8] = write_data[7:0];
                    2'b01:   mem[address[7:2]][{address[1], 4'b0000} +: 16] = write_data[15:0];
                    2'b10:   mem[address[7:2]] = write_data;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_w = mem[address[7:2]] >> {address[1:0], 3'b000};
        case (maskmode)
            2'b00:   read_data = sext ? {24'h0, rd_w[7:0]} : {{24{rd_w[7]}}, rd_w[7:0]};
            2'b01:   read_data = sext ? {16'h0, rd_w[15:0]} : {{16{rd_w[15]}}, rd_w[15:0]};
            2'b10:   read_data = mem[address[7:2]];
            default: read_data = 32'h0;
        endcase
    end

    // Reference model: byte-addressed memory image plus cycle arithmetic for the grant schedule
    logic [7:0] ref_mem [0:255];
    int   tests = 0, fails = 0, t = 0;
    int   free_at = 0, acc_cyc = -10, rsp_cyc = -10;
    bit   prio_c = 1'b1;
    bit   c_want = 0, d_want = 0, c_auto = 0, d_auto = 0;
    req_t c_nx, d_nx;
    bit   e_d, e_bad;
    req_t e_r;
    logic [31:0] e_rdata;
    logic [31:0] last_c_rdata, last_d_rdata;
    logic        last_c_err, last_d_err;
    bit   grant_log [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic bit is_bad(logic [1:0] m, logic [31:0] a);
        return (m == 2'b11) || (m == 2'b01 && a[0]) || (m == 2'b10 && a[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] ref_load(req_t r);
        logic [7:0]  b;
        logic [15:0] h;
        b = ref_mem[r.addr[7:0]];
        h = {ref_mem[r.addr[7:0] + 8'd1], ref_mem[r.addr[7:0]]};
        case (r.mask)
            2'b00:   return r.sext ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   return r.sext ? {16'h0, h} : {{16{h[15]}}, h};
            default: return {ref_mem[r.addr[7:0] + 8'd3], ref_mem[r.addr[7:0] + 8'd2], h};
        endcase
    endfunction

    function automatic void ref_store(req_t r);
        int n;
        n = (r.mask == 2'b00) ? 1 : (r.mask == 2'b01) ? 2 : 4;
        for (int i = 0; i < n; i++) ref_mem[r.addr[7:0] + 8'(i)] = r.wdata[8*i +: 8];
    endfunction

    function automatic void ref_set_word(int wi, logic [31:0] w);
        for (int i = 0; i < 4; i++) ref_mem[4*wi + i] = w[8*i +: 8];
    endfunction

    function automatic req_t rand_req();
        req_t r;
        int   m;
        m       = $urandom_range(0, 6);
        r.we    = 1'($urandom_range(0, 1));
        r.mask  = (m == 6) ? 2'b11 : 2'(m % 3);
        r.sext  = 1'($urandom_range(0, 1));
        r.addr  = 32'($urandom_range(0, 255));
        r.wdata = $urandom;
        if ($urandom_range(0, 3) != 0) begin
            if (r.mask == 2'b01) r.addr[0] = 1'b0;
            if (r.mask[1])       r.addr[1:0] = 2'b00;
        end
        return r;
    endfunction

    task automatic drive();
        c_req = c_want; c_we = c_nx.we; c_mask = c_nx.mask; c_sext = c_nx.sext;
        c_addr = c_nx.addr; c_wdata = c_nx.wdata;
        d_req = d_want; d_we = d_nx.we; d_mask = d_nx.mask; d_sext = d_nx.sext;
        d_addr = d_nx.addr; d_wdata = d_nx.wdata;
    endtask

    task automatic step();
        bit   ec, ed, acc;
        req_t r;
        @(posedge clk);
        t++;
        #1;
        chk1("c_rvalid", c_rvalid, (t == rsp_cyc) && !e_d);
        chk1("d_rvalid", d_rvalid, (t == rsp_cyc) && e_d);
        if (t == rsp_cyc) begin
            if (!e_d) begin
                chk1("c_err", c_err, e_bad);
                chk("c_rdata", c_rdata, e_rdata);
                chk1("d_err_idle", d_err, 1'b0);
                chk("d_rdata_idle", d_rdata, 32'h0);
                last_c_rdata = c_rdata;
                last_c_err   = c_err;
            end else begin
                chk1("d_err", d_err, e_bad);
                chk("d_rdata", d_rdata, e_rdata);
                chk1("c_err_idle", c_err, 1'b0);
                chk("c_rdata_idle", c_rdata, 32'h0);
                last_d_rdata = d_rdata;
                last_d_err   = d_err;
            end
        end
        acc = (t == acc_cyc);
        chk1("mem_write", mem_write, acc && e_r.we && !e_bad);
        chk1("mem_read", mem_read, acc && !e_r.we && !e_bad);
        if (acc && !e_bad) begin
            chk("address", address, e_r.addr);
            chk("maskmode", {30'h0, maskmode}, {30'h0, e_r.mask});
            if (e_r.we) chk("write_data", write_data, e_r.wdata);
            else        chk1("sext", sext, (e_r.mask == 2'b10) ? 1'b0 : e_r.sext);
        end
        drive();
        #1;
        ec = (t >= free_at) && c_want && (!d_want || prio_c);
        ed = (t >= free_at) && d_want && (!c_want || !prio_c);
        chk1("c_ready", c_ready, ec);
        chk1("d_ready", d_ready, ed);
        if (ec || ed) begin
            r       = ed ? d_nx : c_nx;
            e_d     = ed;
            e_r     = r;
            e_bad   = is_bad(r.mask, r.addr);
            e_rdata = (!r.we && !e_bad) ? ref_load(r) : 32'h0;
            if (r.we && !e_bad) ref_store(r);
            prio_c  = ed;
            free_at = t + 3;
            acc_cyc = t + 1;
            rsp_cyc = t + 2;
            grant_log.push_back(ed);
            if (ed) begin
                if (d_auto) d_nx = rand_req(); else d_want = 0;
            end else begin
                if (c_auto) c_nx = rand_req(); else c_want = 0;
            end
        end
    endtask

    task automatic serve(input bit is_d);
        int n = 0;
        while ((is_d ? d_want : c_want) && n < 30) begin
            step();
            n++;
        end
        chk1("serve_timeout", is_d ? d_want : c_want, 1'b0);
    endtask

    task automatic drain();
        repeat (3) step();
    endtask

    initial begin
        logic [31:0] snap;
        for (int i = 0; i < 64; i++) ref_set_word(i, init_word(i));
        c_nx = rand_req();
        d_nx = rand_req();
        e_r  = '0;
        drive();
        c_req = 1'b1;
        d_req = 1'b1;
        #1;
        chk1("rst_c_ready", c_ready, 1'b0);
        chk1("rst_d_ready", d_ready, 1'b0);
        chk1("rst_mem_write", mem_write, 1'b0);
        chk1("rst_mem_read", mem_read, 1'b0);
        chk1("rst_c_rvalid", c_rvalid, 1'b0);
        chk1("rst_d_rvalid", d_rvalid, 1'b0);
        chk("rst_address", address, 32'h0);
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;

        // C-only word store, then byte loads with both extension modes
        c_nx = '{1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF};
        c_want = 1;
        serve(0);
        drain();
        chk("t1_mem_word4", mem[4], 32'hDEADBEEF);
        chk1("t1_err", last_c_err, 1'b0);
        c_nx = '{1'b1, 2'b10, 1'b0, 32'h10, 32'h000000F0};
        c_want = 1;
        serve(0);
        drain();
        c_nx = '{1'b0, 2'b00, 1'b0, 32'h10, 32'h0};
        c_want = 1;
        serve(0);
        drain();
        chk("t2_lb_signed", last_c_rdata, 32'hFFFFFFF0);
        c_nx = '{1'b0, 2'b00, 1'b1, 32'h10, 32'h0};
        c_want = 1;
        serve(0);
        drain();
        chk("t2_lb_zero", last_c_rdata, 32'h000000F0);

        // D misaligned half store and illegal mask
        snap = mem[4];
        d_nx = '{1'b1, 2'b01, 1'b0, 32'h13, 32'hA5A5A5A5};
        d_want = 1;
        serve(1);
        drain();
        chk1("t4_mis_err", last_d_err, 1'b1);
        chk("t4_mis_rdata", last_d_rdata, 32'h0);
        chk("t4_mem_kept", mem[4], snap);
        d_nx = '{1'b0, 2'b11, 1'b0, 32'h14, 32'h0};
        d_want = 1;
        serve(1);
        drain();
        chk1("t4_mask11_err", last_d_err, 1'b1);
        chk("t4_mask11_rdata", last_d_rdata, 32'h0);

        // C lw while D requests continuously
        c_nx = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0};
        d_nx = rand_req();
        d_auto = 1;
        d_want = 1;
        c_want = 1;
        serve(0);
        repeat (6) step();
        d_auto = 0;
        serve(1);
        drain();

        // Reset during the ACCESS cycle of a store, before its negedge
        snap = mem[8];
        c_nx = '{1'b1, 2'b10, 1'b0, 32'h20, ~snap};
        c_want = 1;
        serve(0);
        @(posedge clk);
        t++;
        #1;
        chk1("t5_access_write", mem_write, 1'b1);
        rstn = 1'b0;
        #1;
        chk1("t5_rst_mem_write", mem_write, 1'b0);
        chk1("t5_rst_c_ready", c_ready, 1'b0);
        chk1("t5_rst_d_ready", d_ready, 1'b0);
        drive();
        repeat (2) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk1("t5_no_c_rvalid", c_rvalid, 1'b0);
        chk1("t5_no_d_rvalid", d_rvalid, 1'b0);
        @(negedge clk);
        chk("t5_mem_unchanged", mem[8], snap);
        ref_set_word(8, snap);
        acc_cyc = -10;
        rsp_cyc = -10;
        free_at = 0;
        prio_c  = 1'b1;
        rstn    = 1'b1;

        // Tie held from reset: C first, then strict alternation every 3 cycles
        grant_log.delete();
        c_nx = rand_req();
        d_nx = rand_req();
        c_auto = 1;
        d_auto = 1;
        c_want = 1;
        d_want = 1;
        repeat (12) step();
        chk("t3_grant_count", grant_log.size(), 4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            chk1("t3_grant_order", grant_log[i], (i % 2) == 1);
        c_auto = 0;
        d_auto = 0;
        serve(0);
        serve(1);
        drain();

        // Randomized traffic
        repeat (400) begin
            if (!c_want && $urandom_range(0, 9) < 4) begin
                c_nx = rand_req();
                c_want = 1;
            end
            if (!d_want && $urandom_range(0, 9) < 4) begin
                d_nx = rand_req();
                d_want = 1;
            end
            step();
        end
        c_want = 0;
        d_want = 0;
        drain();
        for (int i = 0; i < 64; i++)
            chk("final_mem", mem[i], {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end
endmodule
